// File: rtl/raster_traverse_pkg.sv
// raster_pkg: shared widths, screen limits and FSM encoding for the rasteriser
package raster_pkg;
  localparam int EW = 20;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  typedef logic signed [EW-1:0] edge_acc_t;
  typedef enum logic [1:0] {IDLE, MUL, INIT, SCAN} raster_state_t;
endpackage

// File: rtl/raster_traverse_edge_stepper.sv
// edge_stepper: incremental evaluator for one edge function across a raster scan
module edge_stepper import raster_pkg::*; #(
  parameter int W = EW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic signed [W-1:0] i_load_val,
  input  logic signed [8:0]   i_a,
  input  logic signed [8:0]   i_b,
  input  logic                i_step_x,
  input  logic                i_step_y,
  output logic signed [W-1:0] o_cur,
  output logic                o_neg
);
  logic signed [W-1:0] r_row, r_cur, w_a, w_b;
  assign w_a = {{(W-9){i_a[8]}}, i_a};
  assign w_b = {{(W-9){i_b[8]}}, i_b};
  // Row start value steps by B on a new row; the running value steps by A along x
  always_ff @(posedge clk)
    if (rst) begin
      r_row <= '0;
      r_cur <= '0;
    end else if (i_load) begin
      r_row <= i_load_val;
      r_cur <= i_load_val;
    end else if (i_step_y) begin
      r_row <= r_row + w_b;
      r_cur <= r_row + w_b;
    end else if (i_step_x)
      r_cur <= r_cur + w_a;
  assign o_cur = r_cur;
  assign o_neg = r_cur[W-1];
endmodule

// File: rtl/raster_traverse.sv
// raster_traverse: walks a triangle's bounding box and emits covered pixels; RASTER_BOTH_WINDING_EN also accepts all-nonpositive edges
module raster_traverse import raster_pkg::*; #(
  parameter int EW = raster_pkg::EW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tri_start,
  input  logic signed [8:0]  i_a1,
  input  logic signed [8:0]  i_a2,
  input  logic signed [8:0]  i_a3,
  input  logic signed [8:0]  i_b1,
  input  logic signed [8:0]  i_b2,
  input  logic signed [8:0]  i_b3,
  input  logic signed [16:0] i_c1,
  input  logic signed [16:0] i_c2,
  input  logic signed [16:0] i_c3,
  input  logic [8:0]         i_bbxi,
  input  logic [8:0]         i_bbxf,
  input  logic [7:0]         i_bbyi,
  input  logic [7:0]         i_bbyf,
  output logic               o_busy,
  output logic               o_pix_valid,
  input  logic               i_pix_ready,
  output logic [8:0]         o_pix_x,
  output logic [7:0]         o_pix_y,
  output logic               o_tri_done
);
  raster_state_t r_state, w_next;
  logic signed [8:0] r_a [3], r_b [3], w_ia [3], w_ib [3];
  logic signed [16:0] r_c [3], w_ic [3];
  logic signed [EW-1:0] r_pa [3], r_pb [3], w_cur [3];
  logic [8:0] r_bxi, r_bxf, r_x;
  logic [7:0] r_byi, r_byf, r_y;
  logic [2:0] w_neg;
  logic w_empty, w_cov, w_adv, w_row_end, w_last, w_done, r_tri_done;
  assign w_ia = '{i_a1, i_a2, i_a3};
  assign w_ib = '{i_b1, i_b2, i_b3};
  assign w_ic = '{i_c1, i_c2, i_c3};
  assign w_empty = r_bxi > r_bxf || r_byi > r_byf;
  assign w_row_end = r_x == r_bxf;
  assign w_last = w_row_end && r_y == r_byf;
`ifdef RASTER_BOTH_WINDING_EN
  logic [2:0] w_zero;
  assign w_zero = {w_cur[2] == '0, w_cur[1] == '0, w_cur[0] == '0};
  assign w_cov = ~|w_neg || &(w_neg | w_zero);
`else
  assign w_cov = ~|w_neg;
`endif
  assign o_pix_valid = r_state == SCAN && w_cov;
  assign w_adv = r_state == SCAN && (!w_cov || i_pix_ready);
  assign o_busy = r_state != IDLE;
  assign o_pix_x = r_x;
  assign o_pix_y = r_y;
  assign o_tri_done = r_tri_done;
  // State register and the registered end-of-triangle pulse
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
    r_tri_done <= !rst && w_done;
  end
  // Next state; done fires on an empty box or on leaving the last position
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (i_tri_start) w_next = MUL;
      MUL: w_next = INIT;
      INIT: begin
        w_next = w_empty ? IDLE : SCAN;
        w_done = w_empty;
      end
      SCAN: if (w_adv && w_last) begin
        w_next = IDLE;
        w_done = 1'b1;
      end
    endcase
  end
  // Capture the triangle only when idle, so a stray start mid-scan is ignored
  always_ff @(posedge clk)
    if (r_state == IDLE && i_tri_start) begin
      r_a <= w_ia;
      r_b <= w_ib;
      r_c <= w_ic;
      r_bxi <= i_bbxi;
      r_bxf <= i_bbxf;
      r_byi <= i_bbyi;
      r_byf <= i_bbyf;
    end
  // Box-origin products, registered so the multipliers stay off the init add path
  always_ff @(posedge clk)
    if (r_state == MUL)
      for (int k = 0; k < 3; k++) begin
        r_pa[k] <= EW'(r_a[k]) * $signed({{(EW-9){1'b0}}, r_bxi});
        r_pb[k] <= EW'(r_b[k]) * $signed({{(EW-8){1'b0}}, r_byi});
      end
  // Raster position: x fastest, wrapping to the box start at each row end
  always_ff @(posedge clk)
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_state == INIT) begin
      r_x <= r_bxi;
      r_y <= r_byi;
    end else if (w_adv) begin
      r_x <= w_row_end ? r_bxi : r_x + 9'd1;
      r_y <= w_row_end ? r_y + 8'd1 : r_y;
    end
  for (genvar k = 0; k < 3; k++) begin : g_edge
    edge_stepper #(.W(EW)) u_step (
      .clk        (clk),
      .rst        (rst),
      .i_load     (r_state == INIT),
      .i_load_val (r_pa[k] + r_pb[k] + EW'(r_c[k])),
      .i_a        (r_a[k]),
      .i_b        (r_b[k]),
      .i_step_x   (w_adv && !w_row_end),
      .i_step_y   (w_adv && w_row_end && r_y != r_byf),
      .o_cur      (w_cur[k]),
      .o_neg      (w_neg[k])
    );
  end
endmodule

// File: doc/raster_traverse.md
Name: raster_traverse

Overview:
- Consumes edge-equation coefficients and the bounding box produced by the edge/bounding-box setup stage.
- Walks every pixel of the box in raster order (x fastest) and evaluates the three edge functions incrementally: add A per x step, add B per row.
- Emits a (x, y) pixel request for each covered pixel over a valid/ready handshake to the framebuffer-write stage.
- One triangle in flight; pulses tri_done when the box is exhausted.

Parameters:
- EW, 20: signed edge accumulator width; holds |A*x + B*y + C| for x<512, y<256 with 9-bit A/B and 17-bit C.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- tri_start  in  1  one-cycle strobe: coefficients and box valid (driven by setup stage's done)
- a1,a2,a3  in  9 signed  edge A coefficients
- b1,b2,b3  in  9 signed  edge B coefficients
- c1,c2,c3  in  17 signed  edge C coefficients
- bbxi, bbxf  in  9  box x start/end, unsigned, inclusive
- bbyi, bbyf  in  8  box y start/end, unsigned, inclusive
- busy  out  1  high from accepted start until tri_done
- pix_valid  out  1  pixel request valid
- pix_ready  in  1  downstream accepts pixel
- pix_x  out  9  pixel x
- pix_y  out  8  pixel y
- tri_done  out  1  one-cycle pulse, triangle finished

Behaviour:
- Reset values: busy=0, pix_valid=0, pix_x=0, pix_y=0, tri_done=0, FSM=IDLE.
- Reset is honoured in any state; a mid-scan reset abandons the triangle with no tri_done.
- FSM has four states: IDLE, MUL, INIT, SCAN.
- IDLE:
  - tri_start=1 latches all coefficients and the box; go to MUL; busy=1 from the next cycle.
  - tri_start outside IDLE is ignored.
- MUL: register the products A_i*bbxi and B_i*bbyi (sign-extend both to EW; box values are zero-extended). Go to INIT.
- INIT:
  - E_i = A_i*bbxi + B_i*bbyi + C_i; load both row_E_i and cur_E_i with E_i; x=bbxi, y=bbyi.
  - If bbxi>bbxf or bbyi>bbyf, pulse tri_done next cycle and return to IDLE; no pixels are emitted.
  - Otherwise go to SCAN.
- SCAN, per position:
  - covered = cur_E1>=0 && cur_E2>=0 && cur_E3>=0.
  - Covered: pix_valid=1 with pix_x=x, pix_y=y. Hold x, y and all E registers stable until pix_ready=1, then advance.
  - Not covered: advance in the same cycle; pix_valid=0.
  - Throughput is 1 position/cycle when unstalled.
- Advance:
  - x<bbxf: x+=1, cur_E_i+=A_i.
  - Else if y<bbyf: x=bbxi, y+=1, row_E_i+=B_i, cur_E_i=row_E_i+B_i.
  - Else (last position): tri_done=1 next cycle, busy=0 with it, go to IDLE.
- Latency: start accepted at edge N → first pix_valid no earlier than after edge N+2.
- The last pixel handshake and tri_done never coincide; tri_done follows by one cycle.
- A new tri_start is accepted in the same cycle tri_done is high (back-to-back triangles).
- Wrap: no wrap; accumulators are sized by EW so they never overflow for legal inputs.

Optional Feature:
- Macro: RASTER_BOTH_WINDING_EN.
- Defined: covered also true when all three cur_E_i<=0, so clockwise and counter-clockwise triangles both rasterise.
- Undefined: only the all->=0 test is used, so the opposite winding is culled.

Decomposition:
- raster_pkg:
  - EW, SCREEN_W=320, SCREEN_H=240
  - typedef edge_acc_t (logic signed [EW-1:0])
  - enum raster_state_t {IDLE, MUL, INIT, SCAN}
- Sub-module edge_stepper, instantiated 3x:
  - holds row_E/cur_E
  - inputs: load value, A, B, step_x, step_y
  - outputs: cur_E and its sign

Test Plan:
- All A=B=0, C=+1, box x 5..7, y 3..4, pix_ready=1 → 6 pixels (5,3),(6,3),(7,3),(5,4),(6,4),(7,4) on consecutive cycles, then a tri_done pulse.
- Same box, a1=1, b1=0, c1=-6, others C=+1 → only (6,3),(7,3),(6,4),(7,4); busy high throughout; one tri_done.
- c1=-1, others as test 1 → zero pix_valid; tri_done 6 scan cycles after INIT.
- Test 1 with pix_ready low for 3 cycles at (6,3) → pix_x/pix_y held at (6,3); no pixel lost or duplicated; total stays 6.
- Degenerate box bbxi=8, bbxf=7 → no pixels; tri_done 3 cycles after start.
- Reset asserted while emitting (6,4) → next cycle pix_valid=0, busy=0, no tri_done. With RASTER_BOTH_WINDING_EN: all C=-1, A=B=0 → 6 pixels; without it → 0 pixels.
